// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional statistics are enabled with PIPE_STAT_EN.
package pipe_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam int DRAIN_DEF = 3;
  localparam int REG_ZERO  = 0;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED,
    STEP
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detection between the ID instruction and a load in EXE.
// Purely combinational.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_is_load,
  input  logic [REG_W-1:0] exe_rd,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;
  logic rd_live;

  assign rs_hit  = id_use_rs & (id_rs == exe_rd);
  assign rt_hit  = id_use_rt & (id_rt == exe_rd);
  assign rd_live = exe_rd != REG_W'(REG_ZERO);

  assign load_use = exe_is_load & rd_live
                  & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and halt/drain/step sequencer for the 5-stage pipeline.
// Define PIPE_STAT_EN to add stall/flush/cycle counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_DEF
`ifdef PIPE_STAT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_is_load,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             exe_branch_taken,
  input  logic             exe_halt,
  input  logic             resume,
  input  logic             step,
  output logic             pc_go,
  output logic             if_id_go,
  output logic             id_exe_go,
  output logic             exe_mem_go,
  output logic             mem_wb_go,
  output logic             if_id_clear,
  output logic             id_exe_clear_one,
  output logic             id_exe_clear_two,
  output logic             halted
`ifdef PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1
                    : $clog2(DRAIN_CYCLES + 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            load_use;

  hazard_detect #(.REG_W(REG_W)) u_hd (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .exe_is_load (exe_is_load),
    .exe_rd      (exe_rd),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    drain_d          = drain_q;
    pc_go            = 1'b1;
    if_id_go         = 1'b1;
    id_exe_go        = 1'b1;
    exe_mem_go       = 1'b1;
    mem_wb_go        = 1'b1;
    if_id_clear      = 1'b0;
    id_exe_clear_one = 1'b0;
    id_exe_clear_two = 1'b0;
    halted           = 1'b0;
    unique case (state_q)
      RUN, STEP: begin
        if (exe_halt) begin
          pc_go            = 1'b0;
          if_id_go         = 1'b0;
          id_exe_clear_one = 1'b1;
          state_d          = DRAIN;
          drain_d          = DW'(DRAIN_CYCLES);
        end else begin
          if (exe_branch_taken) begin
            if_id_clear      = 1'b1;
            id_exe_clear_two = 1'b1;
          end else if (load_use) begin
            pc_go            = 1'b0;
            if_id_go         = 1'b0;
            id_exe_clear_one = 1'b1;
          end
          if (state_q == STEP) state_d = HALTED;
        end
      end
      DRAIN: begin
        // Front end frozen so resume restarts from intact PC/IF_ID.
        pc_go            = 1'b0;
        if_id_go         = 1'b0;
        id_exe_clear_one = 1'b1;
        drain_d          = DW'(drain_q - 1'b1);
        if (drain_q <= DW'(1)) begin
          state_d = HALTED;
          drain_d = '0;
        end
      end
      HALTED: begin
        pc_go      = 1'b0;
        if_id_go   = 1'b0;
        id_exe_go  = 1'b0;
        exe_mem_go = 1'b0;
        mem_wb_go  = 1'b0;
        halted     = 1'b1;
        if (resume)    state_d = RUN;
        else if (step) state_d = STEP;
      end
      default: state_d = RUN;
    endcase
  end

`ifdef PIPE_STAT_EN
  logic active;
  logic stall_ev;
  logic flush_ev;

  assign active   = (state_q == RUN) | (state_q == STEP);
  assign flush_ev = active & ~exe_halt & exe_branch_taken;
  assign stall_ev = active & ~exe_halt & ~exe_branch_taken
                  & load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (stall_ev) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev) flush_cnt <= flush_cnt + 1'b1;
      if (state_q != HALTED) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (table, sequences, random).
// Counter checks are included when PIPE_STAT_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int DC = 3;

  localparam logic [8:0] NORM  = 9'b111110000;
  localparam logic [8:0] STALV = 9'b001110100;
  localparam logic [8:0] FLUSV = 9'b111111010;
  localparam logic [8:0] HALTV = 9'b000000001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, exe_rd;
  logic       id_use_rs, id_use_rt, exe_is_load;
  logic       exe_branch_taken, exe_halt, resume, step;
  logic       pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go;
  logic       if_id_clear, id_exe_clear_one, id_exe_clear_two;
  logic       halted;
  logic [8:0] outs;
`ifdef PIPE_STAT_EN
  logic [31:0] stall_cnt, flush_cnt, cycle_cnt;
`endif

  int nchk = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(DC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_use_rs        (id_use_rs),
    .id_use_rt        (id_use_rt),
    .exe_is_load      (exe_is_load),
    .exe_rd           (exe_rd),
    .exe_branch_taken (exe_branch_taken),
    .exe_halt         (exe_halt),
    .resume           (resume),
    .step             (step),
    .pc_go            (pc_go),
    .if_id_go         (if_id_go),
    .id_exe_go        (id_exe_go),
    .exe_mem_go       (exe_mem_go),
    .mem_wb_go        (mem_wb_go),
    .if_id_clear      (if_id_clear),
    .id_exe_clear_one (id_exe_clear_one),
    .id_exe_clear_two (id_exe_clear_two),
    .halted           (halted)
`ifdef PIPE_STAT_EN
    ,
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt),
    .cycle_cnt        (cycle_cnt)
`endif
  );

  assign outs = {pc_go, if_id_go, id_exe_go, exe_mem_go,
                 mem_wb_go, if_id_clear, id_exe_clear_one,
                 id_exe_clear_two, halted};

  // Reference model: halted flag, drain cycles left, one-shot step.
  bit          m_halted = 0;
  int          m_drain  = 0;
  bit          m_step   = 0;
  int unsigned m_stall  = 0;
  int unsigned m_flush  = 0;
  int unsigned m_cycle  = 0;

  function automatic bit lu_f();
    if (!exe_is_load || exe_rd == 0) return 0;
    if (id_use_rs && id_rs == exe_rd) return 1;
    if (id_use_rt && id_rt == exe_rd) return 1;
    return 0;
  endfunction

  function automatic logic [8:0] model_exp();
    if (m_halted) return HALTV;
    if (m_drain > 0 || exe_halt) return STALV;
    if (exe_branch_taken) return FLUSV;
    if (lu_f()) return STALV;
    return NORM;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halted <= 0;
      m_drain  <= 0;
      m_step   <= 0;
      m_stall  <= 0;
      m_flush  <= 0;
      m_cycle  <= 0;
    end else begin
      if (!m_halted) m_cycle <= m_cycle + 1;
      if (m_halted) begin
        if (resume) begin
          m_halted <= 0;
          m_step   <= 0;
        end else if (step) begin
          m_halted <= 0;
          m_step   <= 1;
        end
      end else if (m_drain > 0) begin
        m_drain <= m_drain - 1;
        if (m_drain == 1) m_halted <= 1;
      end else if (exe_halt) begin
        m_drain <= DC;
        m_step  <= 0;
      end else begin
        if (exe_branch_taken) m_flush <= m_flush + 1;
        else if (lu_f()) m_stall <= m_stall + 1;
        if (m_step) begin
          m_halted <= 1;
          m_step   <= 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic ld, input logic [4:0] rd,
                       input logic br, input logic hlt);
    id_rs            = rs;
    id_rt            = rt;
    id_use_rs        = urs;
    id_use_rt        = urt;
    exe_is_load      = ld;
    exe_rd           = rd;
    exe_branch_taken = br;
    exe_halt         = hlt;
  endtask

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       ld;
    logic [4:0] rd;
    logic       br;
    logic [8:0] exp;
  } vec_t;

  vec_t tv[9];

  initial begin
    tv[0] = '{5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, STALV};
    tv[1] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NORM};
    tv[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, NORM};
    tv[3] = '{5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, STALV};
    tv[4] = '{5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, NORM};
    tv[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, NORM};
    tv[6] = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, FLUSV};
    tv[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, FLUSV};
    tv[8] = '{5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, STALV};

    rst_n  = 1'b0;
    resume = 1'b0;
    step   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 chk("reset_out", outs, NORM);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("after_reset", outs, NORM);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tv[i].rs, tv[i].rt, tv[i].urs, tv[i].urt,
            tv[i].ld, tv[i].rd, tv[i].br, 1'b0);
      #1 chk($sformatf("vec%0d", i), outs, tv[i].exp);
    end

    // Halt pulse, drain with hazards present, then halted.
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("halt_det", outs, STALV);
    for (int k = 0; k < DC; k++) begin
      @(negedge clk) drive(3, 0, 1, 0, 1, 3, 1, 0);
      #1 chk($sformatf("drain%0d", k), outs, STALV);
    end
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("halted", outs, HALTV);

    @(negedge clk) step = 1'b1;
    #1 chk("halt_hold", outs, HALTV);
    @(negedge clk) step = 1'b0;
    #1 chk("step_cycle", outs, NORM);
    @(negedge clk);
    #1 chk("step_back", outs, HALTV);

    @(negedge clk) begin step = 1'b1; resume = 1'b1; end
    @(negedge clk) begin step = 1'b0; resume = 1'b0; end
    #1 chk("resume_run", outs, NORM);
    @(negedge clk);
    #1 chk("resume_stay", outs, NORM);

    // Halt arriving during a single step re-enters drain.
    @(negedge clk) exe_halt = 1'b1;
    @(negedge clk) exe_halt = 1'b0;
    repeat (DC) @(negedge clk);
    #1 chk("halted2", outs, HALTV);
    @(negedge clk) step = 1'b1;
    @(negedge clk) begin step = 1'b0; exe_halt = 1'b1; end
    #1 chk("step_halt", outs, STALV);
    @(negedge clk) exe_halt = 1'b0;
    #1 chk("step_drain", outs, STALV);
    repeat (DC) @(negedge clk);
    #1 chk("halted3", outs, HALTV);
    @(negedge clk) resume = 1'b1;
    @(negedge clk) resume = 1'b0;
    #1 chk("resume2", outs, NORM);

    // Async reset in the second drain cycle.
    @(negedge clk) exe_halt = 1'b1;
    @(negedge clk) exe_halt = 1'b0;
    #1 chk("rd_drain1", outs, STALV);
    @(negedge clk);
    #1 chk("rd_drain2", outs, STALV);
    #1 rst_n = 1'b0;
    #1 chk("rst_async", outs, NORM);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_release", outs, NORM);
    @(negedge clk);
    #1 chk("rst_run", outs, NORM);

`ifdef PIPE_STAT_EN
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) begin
      rst_n = 1'b1;
      drive(4, 0, 1, 0, 1, 4, 0, 0);
    end
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) drive(0, 2, 0, 1, 1, 2, 0, 0);
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (DC + 3) @(negedge clk);
    #1 chk("st_halted", outs, HALTV);
    chk32("stall_cnt", stall_cnt, 2);
    chk32("flush_cnt", flush_cnt, 1);
    chk32("cycle_frozen", cycle_cnt, 8);
`endif

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0));
      resume = ($urandom_range(0, 5) == 0);
      step   = ($urandom_range(0, 3) == 0);
      #1 chk("rand", outs, model_exp());
    end

`ifdef PIPE_STAT_EN
    #1;
    chk32("rand_stall", stall_cnt, m_stall);
    chk32("rand_flush", flush_cnt, m_flush);
    chk32("rand_cycle", cycle_cnt, m_cycle);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, errs);
    $finish;
  end

endmodule
